// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I main control FSM.
// Sequences fetch/decode/execute/memory/writeback over a shared ALU and memory.
module multicycle_ctrl_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter bit         WAIT_MEM    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal,
  output logic       instr_retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_ILLEGAL  = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [3:0] r_state;
  logic       r_illegal;
  logic [3:0] w_next;
  logic       w_rdy;
  logic       w_f3_ok;
  logic [2:0] w_alu_fn;

  assign w_rdy   = WAIT_MEM ? mem_ready : 1'b1;
  assign w_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                   (funct3 == 3'b110) || (funct3 == 3'b111);
  assign illegal = r_illegal;

  // State register; illegal flag sticks until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RESET_STATE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_ILLEGAL)
        r_illegal <= 1'b1;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (w_rdy) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   w_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (w_rdy) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (w_rdy) w_next = S_FETCH;
      S_EXECR,
      S_EXECI:    w_next = w_f3_ok ? S_ALUWB : S_ILLEGAL;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_FETCH;
    endcase
  end

  // ALU function for register/immediate ops; bit30 only means sub on R-type.
  always_comb begin
    w_alu_fn = 3'b000;
    case (funct3)
      3'b000:  w_alu_fn = (r_state == S_EXECR && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  w_alu_fn = 3'b101;
      3'b110:  w_alu_fn = 3'b011;
      3'b111:  w_alu_fn = 3'b010;
      default: w_alu_fn = 3'b000;
    endcase
  end

  // Immediate format straight from the opcode.
  always_comb begin
    imm_src = 2'b00;
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Moore output decode; reset masks every enable.
  always_comb begin
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_control   = 3'b000;
    reg_write     = 1'b0;
    instr_retired = 1'b0;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = w_rdy;
        pc_write   = w_rdy;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write     = 1'b1;
        instr_retired = w_rdy;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = w_alu_fn;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = w_alu_fn;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 2'b10;
        alu_control   = 3'b001;
        pc_write      = zero;
        instr_retired = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      instr_retired = 1'b0;
    end
  end

endmodule
